// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: address/data widths,
// the hardwired-zero register and the writeback requester indices.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;
    localparam int REQ_NUM = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from an internal pointer that
// advances past the winner and holds when nothing is requested.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (|req)
            ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port among the writeback sources and
// tracks long-latency destinations in a busy scoreboard that stalls decode.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = REQ_NUM,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      issue_valid_i,
    input  logic [ADDR_W-1:0]         issue_addr_i,
    output logic                      issue_ready_o,
    input  logic                      readEnable1_i,
    input  logic [ADDR_W-1:0]         readAddr1_i,
    input  logic                      readEnable2_i,
    input  logic [ADDR_W-1:0]         readAddr2_i,
    output logic                      stall_o,
    output logic                      writeEnable_o,
    output logic [ADDR_W-1:0]         writeAddr_o,
    output logic [DATA_W-1:0]         writeData_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic [2**ADDR_W-1:0] busy;
    logic                 issue_take;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid_i),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
                sel_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready_o   = rst ? '0 : gnt;
    assign issue_ready_o = !rst && (!busy[issue_addr_i] || issue_addr_i == '0);
    assign issue_take    = issue_valid_i && issue_ready_o && issue_addr_i != '0;
    // No bypass: a read stalls until the write has actually landed in the array.
    assign stall_o = !rst &&
                     ((readEnable1_i && readAddr1_i != '0 && busy[readAddr1_i]) ||
                      (readEnable2_i && readAddr2_i != '0 && busy[readAddr2_i]));

    always_ff @(posedge clk) begin
        if (rst) begin
            writeEnable_o <= 1'b0;
            writeAddr_o   <= '0;
            writeData_o   <= '0;
        end else if (|gnt) begin
            writeEnable_o <= sel_addr != '0;
            writeAddr_o   <= sel_addr;
            writeData_o   <= sel_data;
        end else begin
            writeEnable_o <= 1'b0;
        end
    end

    // A same-address issue is always refused while busy, so the set never races the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (writeEnable_o) busy[writeAddr_o] <= 1'b0;
            if (issue_take)    busy[issue_addr_i] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: a behavioural model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_regfile_wb_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic        re1, re2;
    logic [4:0]  ra1, ra2;
    logic        stall;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    regfile_wb_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .issue_valid_i (issue_valid),
        .issue_addr_i  (issue_addr),
        .issue_ready_o (issue_ready),
        .readEnable1_i (re1),
        .readAddr1_i   (ra1),
        .readEnable2_i (re2),
        .readAddr2_i   (ra2),
        .stall_o       (stall),
        .writeEnable_o (we),
        .writeAddr_o   (wa),
        .writeData_o   (wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr;
    bit          m_busy [32];
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    function automatic int exp_grant();
        if (rst) return -1;
        for (int i = 0; i < 3; i++) begin
            int k = (m_ptr + i) % 3;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit exp_issue_ready();
        return !rst && (!m_busy[issue_addr] || issue_addr == 5'd0);
    endfunction

    function automatic bit exp_stall();
        return !rst && ((re1 && ra1 != 5'd0 && m_busy[ra1]) ||
                        (re2 && ra2 != 5'd0 && m_busy[ra2]));
    endfunction

    int mg;
    bit mir;
    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_we = 1'b0; m_wa = '0; m_wd = '0;
        end else begin
            mg  = exp_grant();
            mir = exp_issue_ready();
            if (m_we) m_busy[m_wa] = 1'b0;
            if (issue_valid && mir && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
            if (mg >= 0) begin
                m_wa  = req_addr[mg*5 +: 5];
                m_wd  = req_data[mg*32 +: 32];
                m_we  = (m_wa != 5'd0);
                m_ptr = (mg + 1) % 3;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    int cg;
    always @(negedge clk) begin
        if (chk_en) begin
            cg = exp_grant();
            chk("model_ready", {29'd0, req_ready}, (cg < 0) ? 32'd0 : (32'd1 << cg));
            chk("model_issue_ready", {31'd0, issue_ready}, {31'd0, exp_issue_ready()});
            chk("model_stall", {31'd0, stall}, {31'd0, exp_stall()});
            chk("model_we", {31'd0, we}, {31'd0, m_we});
            chk("model_wa", {27'd0, wa}, {27'd0, m_wa});
            chk("model_wd", wd, m_wd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int k, input bit v, input logic [4:0] a, input logic [31:0] d);
        req_valid[k]         = v;
        req_addr[k*5 +: 5]   = a;
        req_data[k*32 +: 32] = d;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 1'b0; issue_addr = '0;
        re1 = 1'b0; re2 = 1'b0; ra1 = '0; ra2 = '0;
        set_req(0, 1'b1, 5'd1, 32'hA1);
        set_req(1, 1'b1, 5'd2, 32'hA2);
        set_req(2, 1'b1, 5'd3, 32'hA3);

        // 1: reset state, then round-robin over three held requests
        step(); chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wa", {27'd0, wa}, 32'd0);
        step(); rst = 1'b0;
        @(negedge clk); chk("rr_g0", {29'd0, req_ready}, 32'b001);
        step();
        @(negedge clk); chk("rr_g1", {29'd0, req_ready}, 32'b010); chk("rr_wa1", {27'd0, wa}, 32'd1);
        step();
        @(negedge clk); chk("rr_g2", {29'd0, req_ready}, 32'b100); chk("rr_wa2", {27'd0, wa}, 32'd2);
        step(); req_valid = '0;
        @(negedge clk); chk("rr_wa3", {27'd0, wa}, 32'd3); chk("rr_we3", {31'd0, we}, 32'd1);
        step();
        @(negedge clk); chk("idle_we", {31'd0, we}, 32'd0);

        // 2: issue 7, decode stalls on 7 until the MDU write lands
        step(); issue_valid = 1'b1; issue_addr = 5'd7; re1 = 1'b1; ra1 = 5'd7;
        @(negedge clk); chk("iss7_ready", {31'd0, issue_ready}, 32'd1); chk("iss7_stall0", {31'd0, stall}, 32'd0);
        step(); issue_valid = 1'b0;
        @(negedge clk); chk("busy7_stall", {31'd0, stall}, 32'd1);
        step(); set_req(2, 1'b1, 5'd7, 32'h77);
        @(negedge clk); chk("mdu_gnt", {29'd0, req_ready}, 32'b100); chk("mdu_t_stall", {31'd0, stall}, 32'd1);
        step(); req_valid[2] = 1'b0;
        @(negedge clk); chk("mdu_we", {31'd0, we}, 32'd1); chk("mdu_wa", {27'd0, wa}, 32'd7);
        chk("mdu_t1_stall", {31'd0, stall}, 32'd1);
        step();
        @(negedge clk); chk("mdu_t2_stall", {31'd0, stall}, 32'd0);

        // 3: WAW refusal, including the cycle the clearing write is in flight
        step(); issue_valid = 1'b1; issue_addr = 5'd7;
        @(negedge clk); chk("reiss7_ok", {31'd0, issue_ready}, 32'd1);
        step(); set_req(2, 1'b1, 5'd7, 32'h99);
        @(negedge clk); chk("waw_refuse", {31'd0, issue_ready}, 32'd0);
        step(); req_valid[2] = 1'b0;
        @(negedge clk); chk("waw_same_cyc", {31'd0, issue_ready}, 32'd0); chk("waw_we", {31'd0, we}, 32'd1);
        step();
        @(negedge clk); chk("waw_retry", {31'd0, issue_ready}, 32'd1); chk("waw_stall0", {31'd0, stall}, 32'd0);
        step(); issue_valid = 1'b0;
        @(negedge clk); chk("waw_busy_again", {31'd0, stall}, 32'd1);

        // 4: LSU write to register 0 is consumed without a write
        step(); set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
        @(negedge clk); chk("z_gnt", {29'd0, req_ready}, 32'b010); chk("z_stall", {31'd0, stall}, 32'd1);
        step(); req_valid[1] = 1'b0;
        @(negedge clk); chk("z_we", {31'd0, we}, 32'd0); chk("z_wd", wd, 32'hDEADBEEF);

        // 5: disabled read and register-0 read never stall
        step(); issue_valid = 1'b1; issue_addr = 5'd5;
        @(negedge clk); chk("iss5_ready", {31'd0, issue_ready}, 32'd1);
        step(); issue_valid = 1'b0; re1 = 1'b0; ra1 = 5'd5; re2 = 1'b1; ra2 = 5'd0;
        @(negedge clk); chk("re_off_stall", {31'd0, stall}, 32'd0);
        step(); ra2 = 5'd5;
        @(negedge clk); chk("re2_busy_stall", {31'd0, stall}, 32'd1);

        // 6: reset mid-stream with busy[4] set and a grant in flight
        step(); re2 = 1'b0; issue_valid = 1'b1; issue_addr = 5'd4;
        @(negedge clk); chk("iss4_ready", {31'd0, issue_ready}, 32'd1);
        step(); issue_valid = 1'b0; re1 = 1'b1; ra1 = 5'd4;
        @(negedge clk); chk("busy4_stall", {31'd0, stall}, 32'd1);
        step();
        set_req(0, 1'b1, 5'd10, 32'h1010);
        set_req(1, 1'b1, 5'd11, 32'h1111);
        set_req(2, 1'b1, 5'd12, 32'h1212);
        @(negedge clk); chk("pre_rst_gnt", {29'd0, req_ready}, 32'b100);
        step(); rst = 1'b1;
        @(negedge clk); chk("mid_rst_ready", {29'd0, req_ready}, 32'd0); chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        step(); rst = 1'b0;
        @(negedge clk); chk("post_rst_we", {31'd0, we}, 32'd0); chk("post_rst_gnt", {29'd0, req_ready}, 32'b001);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        step(); req_valid = '0;
        @(negedge clk); chk("post_rst_wa", {27'd0, wa}, 32'd10); chk("post_rst_we1", {31'd0, we}, 32'd1);
        step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
